// File: rtl/muxn_pkg.sv
//------------------------------------------------------------------------------
// Module   : muxn_pkg
// Brief    : Shared defaults and width helpers for the muxn_rr arbitrated mux.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package muxn_pkg;

  localparam int c_W_DEFAULT = 4;
  localparam int c_N_DEFAULT = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Channel-index width; a single bit is kept even when clog2 would give 0.
  function automatic int ch_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Round-robin one-hot grant: first requester at or above ptr, wrapping.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import muxn_pkg::*;
#(
  parameter int N = c_N_DEFAULT
) (
  input  logic [N-1:0]             req,
  input  logic [ch_width(N)-1:0]   ptr,
  output logic [N-1:0]             grant
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;

  // Requests at or above ptr win; otherwise wrap to the lowest requester.
  assign w_mask = {N{1'b1}} << ptr;
  assign w_hi   = req & w_mask;
  assign grant  = (|w_hi) ? (w_hi & (~w_hi + N'(1))) : (req & (~req + N'(1)));

endmodule

`default_nettype wire

// File: rtl/muxn_rr.sv
//------------------------------------------------------------------------------
// Module   : muxn_rr
// Brief    : N-to-1 round-robin mux with registered valid/ready output stage.
//            Optional packet lock via macro MUXN_RR_LOCK_EN (adds in_last).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module muxn_rr
  import muxn_pkg::*;
#(
  parameter int W = c_W_DEFAULT,
  parameter int N = c_N_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N*W-1:0]           in_data,
  input  logic [N-1:0]             in_valid,
`ifdef MUXN_RR_LOCK_EN
  input  logic [N-1:0]             in_last,
`endif
  output logic [N-1:0]             in_ready,
  output logic [W-1:0]             out_data,
  output logic [ch_width(N)-1:0]   out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int c_CW = ch_width(N);

  logic [c_CW-1:0] r_ptr;
  logic [c_CW-1:0] w_gidx;
  logic [c_CW-1:0] w_ptr_next;
  logic [N-1:0]    w_req;
  logic [N-1:0]    w_grant;
  logic [W-1:0]    w_gdata;
  logic            w_load;
  logic            w_any;

`ifdef MUXN_RR_LOCK_EN
  logic            r_locked;
  logic [c_CW-1:0] r_lock_ch;
  logic            w_last;

  // While a packet is open only the locked channel may be granted.
  assign w_req  = r_locked ? (in_valid & (N'(1) << r_lock_ch)) : in_valid;
  assign w_last = |(in_last & w_grant);
`else
  assign w_req  = in_valid;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign w_load   = !out_valid || out_ready;
  assign w_any    = |w_grant;
  assign in_ready = w_load ? w_grant : '0;

  always_comb begin
    w_gidx  = '0;
    w_gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gidx  = c_CW'(i);
        w_gdata = in_data[i*W +: W];
      end
    end
  end

  assign w_ptr_next = (w_gidx == c_CW'(N-1)) ? '0 : w_gidx + c_CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      r_ptr     <= '0;
`ifdef MUXN_RR_LOCK_EN
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
`endif
    end else if (w_load) begin
      out_valid <= w_any;
      if (w_any) begin
        out_data <= w_gdata;
        out_ch   <= w_gidx;
`ifdef MUXN_RR_LOCK_EN
        r_locked  <= !w_last;
        r_lock_ch <= w_gidx;
        if (w_last) r_ptr <= w_ptr_next;
`else
        r_ptr <= w_ptr_next;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muxn_rr.sv
//------------------------------------------------------------------------------
// Module   : tb_muxn_rr
// Brief    : Directed self-checking bench for muxn_rr (W=4, N=2).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_muxn_rr;

  localparam int W = 4;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [0:0]     out_ch;
  logic           out_valid;
  logic           out_ready = 1'b1;
`ifdef MUXN_RR_LOCK_EN
  logic [N-1:0]   in_last = '1;
`endif

  always #5 clk = ~clk;

  muxn_rr #(.W(W), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef MUXN_RR_LOCK_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard entries are {ch, data}
  logic [4:0] sb[$];

  bit         m_valid = 1'b0;
  logic [3:0] m_data = '0;
  logic       m_ch = 1'b0;
  int         m_ptr = 0;
  bit         m_locked = 1'b0;
  int         m_lock_ch = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_data    = '0;
    m_ch      = 1'b0;
    m_ptr     = 0;
    m_locked  = 1'b0;
    m_lock_ch = 0;
    sb.delete();
  endtask

  task automatic cycle(input logic [1:0] v, input logic [3:0] d0, input logic [3:0] d1,
                       input logic rdy, input logic [1:0] last);
    int         g;
    bit         load;
    logic [1:0] exp_rdy;
    logic [4:0] beat;
    in_valid  = v;
    in_data   = {d1, d0};
    out_ready = rdy;
`ifdef MUXN_RR_LOCK_EN
    in_last   = last;
`endif
    load = !m_valid || rdy;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g < 0 && ((v >> idx) & 2'b01) != 2'b00 && (!m_locked || idx == m_lock_ch))
        g = idx;
    end
    exp_rdy = (load && g >= 0) ? 2'(1 << g) : 2'b00;
    #1;
    check("in_ready", 8'(in_ready), 8'(exp_rdy));
    if (load) begin
      if (g >= 0) begin
        sb.push_back({1'(g), (g == 1) ? d1 : d0});
        m_valid = 1'b1;
`ifdef MUXN_RR_LOCK_EN
        if (((last >> g) & 2'b01) != 2'b00) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
        end else begin
          m_locked  = 1'b1;
          m_lock_ch = g;
        end
`else
        if (last == 2'b00) m_ptr = (g + 1) % N;
        else               m_ptr = (g + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", 8'(out_valid), 8'(m_valid));
    if (load && g >= 0) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        beat   = sb.pop_front();
        m_data = beat[3:0];
        m_ch   = beat[4];
      end
    end
    if (m_valid) begin
      check("out_data", 8'(out_data), 8'(m_data));
      check("out_ch", 8'(out_ch), 8'(m_ch));
    end
  endtask

  initial begin
    // Reset held from time 0
    #2;
    check("rst_valid", 8'(out_valid), 8'h00);
    check("rst_data", 8'(out_data), 8'h00);
    check("rst_ch", 8'(out_ch), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Single channel, then drain; ptr must stay at 1 so ch1 wins next
    cycle(2'b01, 4'b0000, 4'b1111, 1'b1, 2'b11);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1, 2'b11);
    cycle(2'b11, 4'b0101, 4'b1010, 1'b1, 2'b11);
    check("ptr_kept_ch1", 8'(out_ch), 8'h01);

    // Alternation, one beat per cycle
    for (int i = 0; i < 6; i++) cycle(2'b11, 4'b0001, 4'b0010, 1'b1, 2'b11);

    // Backpressure then release
    for (int i = 0; i < 3; i++) cycle(2'b11, 4'b0111, 4'b1000, 1'b0, 2'b11);
    cycle(2'b11, 4'b0111, 4'b1000, 1'b1, 2'b11);
    cycle(2'b10, 4'b0000, 4'b1100, 1'b1, 2'b11);

    // Drain
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1, 2'b11);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1, 2'b11);
    cycle(2'b10, 4'b0000, 4'b0110, 1'b1, 2'b11);

    // Asynchronous reset mid-stream with a beat held
    cycle(2'b11, 4'b1001, 4'b0011, 1'b0, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", 8'(out_valid), 8'h00);
    check("midrst_data", 8'(out_data), 8'h00);
    check("midrst_ch", 8'(out_ch), 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(2'b11, 4'b1110, 4'b1101, 1'b1, 2'b11);
    check("post_rst_ch0", 8'(out_ch), 8'h00);
    cycle(2'b11, 4'b1110, 4'b1101, 1'b1, 2'b11);

`ifdef MUXN_RR_LOCK_EN
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1, 2'b11);
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(2'b11, 4'b0001, 4'b1000, 1'b1, 2'b00);
    cycle(2'b10, 4'b0010, 4'b1000, 1'b1, 2'b00);
    cycle(2'b11, 4'b0010, 4'b1000, 1'b1, 2'b00);
    cycle(2'b11, 4'b0011, 4'b1000, 1'b1, 2'b01);
    cycle(2'b11, 4'b0100, 4'b1000, 1'b1, 2'b11);
    check("lock_then_ch1", 8'(out_ch), 8'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muxn_rr.md
MUXN_RR -- requirements
Module: muxn_rr

Interface
REQ-001 SHALL have parameter W, default 4, data width per channel in bits (W >= 1).
REQ-002 SHALL have parameter N, default 2, number of input channels (N >= 2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-006 SHALL have port in_valid  input  N  per-channel data-valid.
REQ-007 SHALL have port in_ready  output  N  per-channel accept; a beat transfers when in_valid[i] && in_ready[i].
REQ-008 SHALL have port out_data  output  W  registered selected data.
REQ-009 SHALL have port out_ch  output  max(1,clog2(N))  index of the channel that sourced out_data.
REQ-010 SHALL have port out_valid  output  1  out_data/out_ch hold a valid beat.
REQ-011 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-012 SHALL define load = !out_valid || out_ready; the output register accepts a new beat only when load is 1.
REQ-013 SHALL grant at most one channel per cycle: the first channel with in_valid=1 searching upward (with wrap-around) from ptr.
REQ-014 SHALL drive in_ready[i]=1 only for the granted channel and only when load=1; all other in_ready bits are 0. in_ready is combinational from in_valid, ptr, out_valid and out_ready.
REQ-015 SHALL, on a transfer from channel g, register out_data=in_data[g], out_ch=g, out_valid=1 at the next edge. Latency is one cycle.
REQ-016 SHALL, after a transfer from channel g, set ptr=(g+1) mod N. Wrap-around: g=N-1 sets ptr=0.
REQ-017 SHALL, when load=1 and no in_valid bit is set, clear out_valid at the next edge and leave ptr unchanged.
REQ-018 SHALL hold out_data, out_ch and out_valid stable while out_valid=1 && out_ready=0.
REQ-019 SHALL give full throughput: when out_valid=1 && out_ready=1 and a channel is valid, a new beat is loaded in the same cycle.
REQ-020 SHALL ensure a channel that stays valid is granted within N transfers (no starvation).

Reset
REQ-021 SHALL, while reset=1, force out_valid=0, out_data=0, out_ch=0 and ptr=0, independent of clk.
REQ-022 SHALL drop any beat held in the output register when reset asserts mid-operation; after release, channel 0 has highest priority.

Configuration
REQ-023 SHALL support macro MUXN_RR_LOCK_EN. When defined, it adds input port in_last (N bits, paired per channel).
REQ-024 SHALL, with MUXN_RR_LOCK_EN defined, keep the grant locked on the current channel after a transfer with in_last[g]=0. ptr advances per REQ-016 only on a transfer with in_last[g]=1.
REQ-025 SHALL, with MUXN_RR_LOCK_EN defined, keep the grant locked while the locked channel has in_valid=0; no other channel is granted.
REQ-026 SHALL, without MUXN_RR_LOCK_EN, omit the in_last port and re-arbitrate on every beat.

Structure
REQ-027 SHALL place the clog2 helper function and the default W/N constants in shared package muxn_pkg.
REQ-028 SHALL implement grant selection in sub-module rr_arbiter (inputs req[N] and ptr; output one-hot grant). muxn_rr contains the output register, the ptr register and the lock register.

Verification (W=4, N=2, out_ready=1 unless stated)
REQ-029 SHALL check reset: assert reset mid-stream with out_valid=1 -> out_valid=0, out_data=0000 immediately; ptr=0 after release.
REQ-030 SHALL check single channel: ch0=0000 valid, ch1 idle -> next cycle out_data=0000, out_ch=0, out_valid=1.
REQ-031 SHALL check alternation: both channels valid continuously, a=0001, b=0010 -> out_data alternates 0001, 0010, 0001... and out_ch alternates 0, 1, 0... with one beat per cycle.
REQ-032 SHALL check backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable, in_ready=00. out_ready=1 -> next beat loaded the same cycle.
REQ-033 SHALL check drain: all in_valid=0 with out_ready=1 -> out_valid=0 next cycle; ptr unchanged.
REQ-034 SHALL check lock (MUXN_RR_LOCK_EN defined): ch0 sends 3 beats with in_last=0,0,1 while ch1 is valid -> out_ch=0,0,0 then 1.
